// File: rtl/depkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : depkt_pkg
// Brief    : Shared constants and helpers for the UDP IQ depacketizer.
// Revision : 1.0
// ============================================================================
package depkt_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_TRAIL   = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    localparam logic [3:0] W_DMAC_HI = 4'd0;
    localparam logic [3:0] W_DMAC_LO = 4'd1;
    localparam logic [3:0] W_ETYPE   = 4'd3;
    localparam logic [3:0] W_IPVER   = 4'd4;
    localparam logic [3:0] W_PROTO   = 4'd6;
    localparam logic [3:0] W_DIP     = 4'd8;
    localparam logic [3:0] W_PORTS   = 4'd9;
    localparam logic [3:0] W_UDPLEN  = 4'd10;
    localparam logic [3:0] W_SEQ_LO  = 4'd11;
    localparam logic [3:0] W_SEQ_HI  = 4'd12;
    localparam logic [3:0] W_IQ0     = 4'd13;

    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL        = 8'h45;
    localparam logic [7:0]  PROTO_UDP         = 8'h11;
    localparam logic [15:0] UDP_HDR_PLUS_SEQ  = 16'd16;

    function automatic logic [13:0] iq_words_of(input logic [15:0] udplen);
        return 14'((udplen - UDP_HDR_PLUS_SEQ) >> 2);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Wire order is {I lo, I hi, Q lo, Q hi}; the FIFO wants {I, Q}.
    function automatic logic [31:0] iq_unswap(input logic [31:0] w);
        return {w[23:16], w[31:24], w[7:0], w[15:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/depacketizer_if.sv
`default_nettype none
// ============================================================================
// Module   : depacketizer_if
// Brief    : MAC RX stream plus sample-FIFO write port of the depacketizer.
// Revision : 1.0
// ============================================================================
interface depacketizer_if;
    logic [31:0] rx_data;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic        rx_dval;
    logic [1:0]  rx_mod;
    logic        rx_rdy;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full;

    modport master (
        output rx_data, rx_sop, rx_eop, rx_err, rx_dval, rx_mod, wr_full,
        input  rx_rdy, wr_en, wr_data
    );

    modport slave (
        input  rx_data, rx_sop, rx_eop, rx_err, rx_dval, rx_mod, wr_full,
        output rx_rdy, wr_en, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/depkt_seq_check.sv
`default_nettype none
// ============================================================================
// Module   : depkt_seq_check
// Brief    : Tracks the 64-bit frame sequence and counts missing frames.
// Revision : 1.0
// ============================================================================
module depkt_seq_check
    import depkt_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic [31:0] i_seq_lo,
    input  wire logic [31:0] i_seq_hi,
    input  wire logic        i_frame_ok,
    output logic      [31:0] o_lost_cnt
);

    logic [63:0] r_expected;
    logic        r_init;
    logic [31:0] r_lost;

    logic [63:0] w_seq;
    logic [63:0] w_gap;
    logic [64:0] w_sum;
    logic [31:0] w_lost_nxt;

    assign w_seq = {bswap32(i_seq_hi), bswap32(i_seq_lo)};
    assign w_gap = w_seq - r_expected;
    assign w_sum = {33'd0, r_lost} + {1'b0, w_gap};
    assign w_lost_nxt = (w_sum[64:32] != 33'd0) ? 32'hFFFF_FFFF : w_sum[31:0];

    // A backwards jump only resynchronises; the first frame only seeds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_expected <= 64'd0;
            r_init     <= 1'b0;
            r_lost     <= 32'd0;
        end else if (i_frame_ok) begin
            r_expected <= w_seq + 64'd1;
            r_init     <= 1'b1;
            if (r_init && (w_seq > r_expected))
                r_lost <= w_lost_nxt;
        end
    end

    assign o_lost_cnt = r_lost;

endmodule
`default_nettype wire

// File: rtl/depacketizer.sv
`default_nettype none
// ============================================================================
// Module   : depacketizer
// Brief    : Validates Eth/IPv4/UDP frames and writes {I,Q} samples to FIFO.
//            Optional sequence-loss tracking when DEPKT_SEQ_CHECK_EN is defined.
// Revision : 1.0
// ============================================================================
module depacketizer
    import depkt_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC    = 48'h02_12_34_56_67_90,
    parameter logic [31:0] LOCAL_IP     = {8'd192, 8'd168, 8'd50, 8'd50},
    parameter logic [15:0] LOCAL_PORT   = 16'd32179,
    parameter bit          ACCEPT_BCAST = 1'b0
)(
    input  wire logic       clk,
    input  wire logic       reset_n,
    depacketizer_if.slave   bus,
    output logic     [31:0] frame_ok_cnt,
    output logic     [31:0] frame_drop_cnt,
    output logic     [31:0] lost_cnt
);

    logic [2:0]  r_state;
    logic [3:0]  r_w;
    logic [13:0] r_cnt;
    logic [13:0] r_iq_words;
    logic        r_bcast;
    logic        r_wr_en;
    logic [31:0] r_wr_data;
    logic [31:0] r_ok_cnt;
    logic [31:0] r_drop_cnt;

    logic        w_rdy;
    logic        w_beat;
    logic        w_w0_bcast;
    logic        w_w0_ok;
    logic        w_word_ok;
    logic        w_last;
    logic [2:0]  w_state_nxt;
    logic [3:0]  w_w_nxt;
    logic [13:0] w_cnt_nxt;
    logic        w_ok_inc;
    logic [1:0]  w_drop_inc;
    logic        w_wr;

    assign w_rdy  = reset_n & ~((r_state == S_PAYLOAD) & bus.wr_full);
    assign w_beat = bus.rx_dval & w_rdy;
    assign w_last = ((r_cnt + 14'd1) == r_iq_words);

    assign w_w0_bcast = ACCEPT_BCAST && (bus.rx_data[15:0] == 16'hFFFF);
    assign w_w0_ok    = (bus.rx_data[15:0] == LOCAL_MAC[47:32]) || w_w0_bcast;

    always_comb begin
        w_word_ok = 1'b1;
        case (r_w)
            W_DMAC_LO: w_word_ok = r_bcast ? (bus.rx_data == 32'hFFFF_FFFF)
                                           : (bus.rx_data == LOCAL_MAC[31:0]);
            W_ETYPE:   w_word_ok = (bus.rx_data[15:0] == ETHERTYPE_IPV4);
            W_IPVER:   w_word_ok = (bus.rx_data[31:24] == IP_VER_IHL);
            W_PROTO:   w_word_ok = (bus.rx_data[23:16] == PROTO_UDP);
            W_DIP:     w_word_ok = (bus.rx_data == LOCAL_IP);
            W_PORTS:   w_word_ok = (bus.rx_data[15:0] == LOCAL_PORT);
            W_UDPLEN:  w_word_ok = (bus.rx_data[31:16] >= UDP_HDR_PLUS_SEQ) &&
                                   (bus.rx_data[17:16] == 2'b00);
            default:   w_word_ok = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_cnt_nxt   = r_cnt;
        w_ok_inc    = 1'b0;
        w_drop_inc  = 2'd0;
        w_wr        = 1'b0;
        if (w_beat) begin
            if (bus.rx_sop) begin
                // An sop anywhere aborts the frame in flight and restarts at word 0.
                if (r_state != S_IDLE)
                    w_drop_inc = 2'd1;
                w_w_nxt = 4'd1;
                if (bus.rx_eop) begin
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = w_w0_ok ? S_HDR : S_DROP;
                end
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_HDR: begin
                        if (!w_word_ok) begin
                            if (bus.rx_eop) begin
                                w_drop_inc  = 2'd1;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_DROP;
                            end
                        end else if (r_w == W_SEQ_HI) begin
                            w_cnt_nxt = 14'd0;
                            if (r_iq_words == 14'd0) begin
                                if (bus.rx_eop && bus.rx_err)
                                    w_drop_inc = 2'd1;
                                else
                                    w_ok_inc = 1'b1;
                                w_state_nxt = S_IDLE;
                            end else if (bus.rx_eop) begin
                                w_drop_inc  = 2'd1;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_PAYLOAD;
                            end
                        end else if (bus.rx_eop) begin
                            w_drop_inc  = 2'd1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_w_nxt = r_w + 4'd1;
                        end
                    end
                    S_PAYLOAD: begin
                        w_wr      = 1'b1;
                        w_cnt_nxt = r_cnt + 14'd1;
                        if (bus.rx_eop) begin
                            if (w_last && !bus.rx_err)
                                w_ok_inc = 1'b1;
                            else
                                w_drop_inc = 2'd1;
                            w_state_nxt = S_IDLE;
                        end else if (w_last) begin
                            w_state_nxt = S_TRAIL;
                        end
                    end
                    S_TRAIL: begin
                        if (bus.rx_eop) begin
                            if (bus.rx_err)
                                w_drop_inc = 2'd1;
                            else
                                w_ok_inc = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_DROP: begin
                        if (bus.rx_eop) begin
                            w_drop_inc  = 2'd1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_w        <= 4'd0;
            r_cnt      <= 14'd0;
            r_iq_words <= 14'd0;
            r_bcast    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= 32'd0;
            r_ok_cnt   <= 32'd0;
            r_drop_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr_en <= w_wr;
            if (w_beat && bus.rx_sop)
                r_bcast <= w_w0_bcast;
            if (w_beat && !bus.rx_sop && (r_state == S_HDR) && (r_w == W_UDPLEN))
                r_iq_words <= iq_words_of(bus.rx_data[31:16]);
            if (w_wr)
                r_wr_data <= iq_unswap(bus.rx_data);
            r_ok_cnt   <= r_ok_cnt + {31'd0, w_ok_inc};
            r_drop_cnt <= r_drop_cnt + {30'd0, w_drop_inc};
        end
    end

    assign bus.rx_rdy     = w_rdy;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_data    = r_wr_data;
    assign frame_ok_cnt   = r_ok_cnt;
    assign frame_drop_cnt = r_drop_cnt;

`ifdef DEPKT_SEQ_CHECK_EN
    logic [31:0] r_seq_lo;
    logic [31:0] r_seq_hi;
    logic [31:0] w_seq_hi;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seq_lo <= 32'd0;
            r_seq_hi <= 32'd0;
        end else if (w_beat && !bus.rx_sop && (r_state == S_HDR)) begin
            if (r_w == W_SEQ_LO)
                r_seq_lo <= bus.rx_data;
            if (r_w == W_SEQ_HI)
                r_seq_hi <= bus.rx_data;
        end
    end

    // A frame with no IQ words completes on the seq-high beat itself.
    assign w_seq_hi = (r_state == S_HDR) ? bus.rx_data : r_seq_hi;

    depkt_seq_check u_seq_check (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_seq_lo   (r_seq_lo),
        .i_seq_hi   (w_seq_hi),
        .i_frame_ok (w_ok_inc),
        .o_lost_cnt (lost_cnt)
    );
`else
    assign lost_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_depacketizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_depacketizer
// Brief    : Randomized frame stimulus against a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_depacketizer;

    localparam logic [47:0] C_MAC  = 48'h02_12_34_56_67_90;
    localparam logic [15:0] C_PORT = 16'd32179;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    depacketizer_if bus();
    logic [31:0] ok_cnt, drop_cnt, lost_cnt;

    depacketizer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .frame_ok_cnt   (ok_cnt),
        .frame_drop_cnt (drop_cnt),
        .lost_cnt       (lost_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0]     exp_q[$];
    int              n_wr = 0;
    int              n_exp_wr = 0;
    longint unsigned m_ok = 0, m_drop = 0, m_lost = 0, m_expect = 0;
    bit              m_init = 0;

    logic [31:0] fr[$];
    logic [31:0] fsamp[$];
    int  stall_left = 0;
    bit  force_full = 0;
    bit  rand_mode  = 0;

    int          cidx[8]  = '{0, 1, 3, 4, 6, 8, 9, 10};
    logic [31:0] cmask[8] = '{32'h1, 32'h1, 32'h1, 32'h0100_0000, 32'h0001_0000,
                              32'h1, 32'h1, 32'h0002_0000};

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0)
                check("wr_unexpected", n_wr, n_exp_wr);
            else
                check("wr_data", bus.wr_data, exp_q.pop_front());
        end
    end

    task automatic build(input logic [47:0] dmac, input logic [15:0] dport,
                         input logic [63:0] seq, input int niq, input int npad);
        logic [15:0] udplen;
        udplen = 16'(16 + 4 * niq);
        fr.delete();
        fsamp.delete();
        fr.push_back({16'h0000, dmac[47:32]});
        fr.push_back(dmac[31:0]);
        fr.push_back(32'h0011_2233);
        fr.push_back({16'h4455, 16'h0800});
        fr.push_back({8'h45, 8'h00, udplen + 16'd20});
        fr.push_back($urandom);
        fr.push_back({8'd64, 8'h11, 16'h0000});
        fr.push_back({8'd192, 8'd168, 8'd50, 8'd1});
        fr.push_back({8'd192, 8'd168, 8'd50, 8'd50});
        fr.push_back({16'd5000, dport});
        fr.push_back({udplen, 16'h0000});
        fr.push_back({seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
        fr.push_back({seq[39:32], seq[47:40], seq[55:48], seq[63:56]});
        for (int i = 0; i < niq; i++) begin
            logic [31:0] s;
            s = $urandom;
            fsamp.push_back(s);
            fr.push_back({s[23:16], s[31:24], s[7:0], s[15:8]});
        end
        for (int i = 0; i < npad; i++)
            fr.push_back($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_dval = 1'b0;
            bus.rx_sop  = 1'b0;
            bus.rx_eop  = 1'b0;
            bus.rx_err  = 1'b0;
            bus.wr_full = 1'b0;
        end
    endtask

    task automatic beat(input logic [31:0] d, input bit s, input bit e, input bit er,
                        input bit is_samp, input logic [31:0] samp, input bit rdy_high);
        bit acc;
        bit stalled;
        int guard;
        acc = 0;
        guard = 0;
        if (rand_mode && ($urandom_range(0, 3) == 0))
            idle(1);
        while (!acc) begin
            @(negedge clk);
            bus.rx_data = d;
            bus.rx_sop  = s;
            bus.rx_eop  = e;
            bus.rx_err  = er;
            bus.rx_mod  = 2'd0;
            bus.rx_dval = 1'b1;
            stalled = (stall_left > 0);
            if (stalled) begin
                bus.wr_full = 1'b1;
                stall_left--;
            end else if (force_full)
                bus.wr_full = 1'b1;
            else if (rand_mode)
                bus.wr_full = ($urandom_range(0, 5) == 0);
            else
                bus.wr_full = 1'b0;
            #1;
            if (stalled)  check("stall_rdy", bus.rx_rdy, 0);
            if (rdy_high) check("drop_rdy", bus.rx_rdy, 1);
            acc = bus.rx_rdy;
            @(posedge clk);
            if (!acc) begin
                guard++;
                if (guard > 50) begin
                    check("beat_timeout", guard, 0);
                    acc = 1;
                end
            end
        end
        if (is_samp) begin
            exp_q.push_back(samp);
            n_exp_wr++;
        end
    endtask

    // Samples are expected only for payload words of a frame whose header is good.
    task automatic send(input int nsend, input bit hdr_ok, input bit last_eop,
                        input bit err, input int stall_at, input bit rdy_high);
        for (int i = 0; i < nsend; i++) begin
            bit e, smp;
            logic [31:0] sv;
            e   = last_eop && (i == nsend - 1);
            smp = 0;
            sv  = 32'h0;
            if (hdr_ok && i >= 13 && (i - 13) < fsamp.size()) begin
                smp = 1;
                sv  = fsamp[i - 13];
            end
            if (i == stall_at) stall_left = 5;
            beat(fr[i], i == 0, e, e && err, smp, sv, rdy_high);
        end
        idle(1);
    endtask

    task automatic frame_end(input bit ok, input logic [63:0] seq);
        if (!ok) m_drop++;
        else begin
            m_ok++;
`ifdef DEPKT_SEQ_CHECK_EN
            if (m_init && seq > m_expect) begin
                m_lost = m_lost + (seq - m_expect);
                if (m_lost > 64'hFFFF_FFFF) m_lost = 64'hFFFF_FFFF;
            end
            m_init   = 1;
            m_expect = seq + 64'd1;
`endif
        end
    endtask

    task automatic verify(input string tag);
        idle(2);
        check({tag, "_ok"}, ok_cnt, m_ok[31:0]);
        check({tag, "_drop"}, drop_cnt, m_drop[31:0]);
        check({tag, "_lost"}, lost_cnt, m_lost[31:0]);
        check({tag, "_nwr"}, n_wr, n_exp_wr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] sq;
        int kind, niq, k, ci;
        bus.rx_data = 32'd0; bus.rx_sop = 0; bus.rx_eop = 0; bus.rx_err = 0;
        bus.rx_dval = 0; bus.rx_mod = 2'd0; bus.wr_full = 0;
        repeat (3) @(negedge clk);
        check("rst_rdy", bus.rx_rdy, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_ok", ok_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        reset_n = 1'b1;

        // 366-sample frame with a known first sample
        build(C_MAC, C_PORT, 64'd5, 366, 0);
        fsamp[0] = 32'h1234_5678;
        fr[13]   = 32'h3412_7856;
        send(fr.size(), 1, 1, 0, -1, 0);
        frame_end(1, 64'd5);
        verify("t1");
        check("t1_count", n_wr, 366);

        // Wrong dport while FIFO reports full: nothing written, rdy high
        build(C_MAC, 16'd32180, 64'd6, 366, 0);
        force_full = 1;
        send(fr.size(), 0, 1, 0, -1, 1);
        force_full = 0;
        frame_end(0, 64'd0);
        verify("t2");

        // Five-cycle FIFO stall mid-payload
        build(C_MAC, C_PORT, 64'd6, 366, 0);
        send(fr.size(), 1, 1, 0, 100, 0);
        frame_end(1, 64'd6);
        verify("t3");
        check("t3_count", n_wr, 732);

        // Sequence jump then backwards resync
        build(C_MAC, C_PORT, 64'd9, 4, 2);
        send(fr.size(), 1, 1, 0, -1, 0);
        frame_end(1, 64'd9);
        verify("t4a");
        build(C_MAC, C_PORT, 64'd3, 0, 0);
        send(fr.size(), 1, 1, 0, -1, 0);
        frame_end(1, 64'd3);
        verify("t4b");

        // eop at word 8
        build(C_MAC, C_PORT, 64'd4, 8, 0);
        send(9, 1, 1, 0, -1, 0);
        frame_end(0, 64'd0);
        verify("t5");

        // New sop mid-payload aborts the previous frame
        build(C_MAC, C_PORT, 64'd10, 50, 0);
        send(30, 1, 0, 0, -1, 0);
        build(C_MAC, C_PORT, 64'd11, 8, 0);
        send(fr.size(), 1, 1, 0, -1, 0);
        frame_end(0, 64'd0);
        frame_end(1, 64'd11);
        verify("t6");

        // Broadcast rejected by default; rx_err on a good frame
        build(48'hFFFF_FFFF_FFFF, C_PORT, 64'd12, 3, 0);
        send(fr.size(), 0, 1, 0, -1, 0);
        frame_end(0, 64'd0);
        build(C_MAC, C_PORT, 64'd12, 6, 0);
        send(fr.size(), 1, 1, 1, -1, 0);
        frame_end(0, 64'd0);
        verify("t7");

        // Randomized mix
        rand_mode = 1;
        sq = 64'd12;
        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 5);
            niq  = $urandom_range(1, 12);
            case (kind)
                0, 1: begin
                    sq = ($urandom_range(0, 4) == 0) ? sq - 64'd2 : sq + 64'($urandom_range(1, 3));
                    niq = $urandom_range(0, 12);
                    build(C_MAC, C_PORT, sq, niq, $urandom_range(0, 2));
                    send(fr.size(), 1, 1, 0, -1, 0);
                    frame_end(1, sq);
                end
                2: begin
                    build(C_MAC, C_PORT, sq, niq, 0);
                    ci = $urandom_range(0, 7);
                    fr[cidx[ci]] = fr[cidx[ci]] ^ cmask[ci];
                    send(fr.size(), 0, 1, 0, -1, 0);
                    frame_end(0, 64'd0);
                end
                3: begin
                    build(C_MAC, C_PORT, sq, niq, 0);
                    send($urandom_range(1, 12), 1, 1, 0, -1, 0);
                    frame_end(0, 64'd0);
                end
                4: begin
                    build(C_MAC, C_PORT, sq, niq, 0);
                    send(fr.size(), 1, 1, 1, -1, 0);
                    frame_end(0, 64'd0);
                end
                default: begin
                    build(C_MAC, C_PORT, sq, niq, 0);
                    k = $urandom_range(0, niq - 1);
                    send(13 + k, 1, 1, 0, -1, 0);
                    frame_end(0, 64'd0);
                end
            endcase
            verify("rnd");
        end
        rand_mode = 0;

        // Reset mid-payload
        build(C_MAC, C_PORT, 64'd100, 366, 0);
        send(113, 1, 0, 0, -1, 0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_rdy", bus.rx_rdy, 0);
        check("mrst_wr_en", bus.wr_en, 0);
        check("mrst_wr_data", bus.wr_data, 0);
        check("mrst_ok", ok_cnt, 0);
        check("mrst_drop", drop_cnt, 0);
        check("mrst_lost", lost_cnt, 0);
        reset_n = 1'b1;
        m_ok = 0; m_drop = 0; m_lost = 0; m_expect = 0; m_init = 0;
        build(C_MAC, C_PORT, 64'd7, 10, 0);
        send(fr.size(), 1, 1, 0, -1, 0);
        frame_end(1, 64'd7);
        verify("t8");

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
